// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic skew feeder.
// Other files import this package with import systolic_pkg::*.
package systolic_pkg;

   localparam int DEF_ARRAY_DIM   = 32;
   localparam int DEF_DATA_W      = 8;
   localparam int DEF_K_MAX       = 64;
   localparam int DEF_DRAIN_EXTRA = 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STREAM,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Operand load path into the skew feeder.
// Carries one A column beat and one B row beat per handshake.
interface systolic_skew_feeder_if
   import systolic_pkg::*;
#(
   parameter int ARRAY_DIM = DEF_ARRAY_DIM,
   parameter int DATA_W    = DEF_DATA_W
);

   logic                        a_wr_valid;
   logic                        a_wr_ready;
   logic [ARRAY_DIM*DATA_W-1:0] a_wr_data;
   logic                        b_wr_valid;
   logic                        b_wr_ready;
   logic [ARRAY_DIM*DATA_W-1:0] b_wr_data;

   modport master (
      output a_wr_valid, a_wr_data,
      output b_wr_valid, b_wr_data,
      input  a_wr_ready, b_wr_ready
   );

   modport slave (
      input  a_wr_valid, a_wr_data,
      input  b_wr_valid, b_wr_data,
      output a_wr_ready, b_wr_ready
   );

endinterface

// File: rtl/systolic_skew_feeder_lane_buf.sv
// One edge lane: k-indexed operand buffer plus skewed,
// zero-gated, registered injection output.
module skew_lane_buf #(
   parameter int LANE   = 0,
   parameter int DATA_W = 8,
   parameter int K_MAX  = 64,
   parameter int AW     = (K_MAX > 1) ? $clog2(K_MAX) : 1,
   parameter int KW     = $clog2(K_MAX + 1),
   parameter int T_W    = $clog2(K_MAX + 32)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [T_W-1:0]    rd_t,
   input  logic [KW-1:0]     k,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid
);

   logic [DATA_W-1:0] mem [K_MAX];
   logic [T_W-1:0]    off;
   logic [AW-1:0]     rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              win;

   // Bypass covers K=1, where lane 0 reads the beat landing this edge.
   always_comb begin
      off     = rd_t - T_W'(LANE);
      win     = rd_en
             && (rd_t >= T_W'(LANE))
             && (off < T_W'(k));
      rd_addr = off[AW-1:0];
      rd_data = '0;
      if (win) begin
         if (we && (wr_addr == rd_addr))
            rd_data = wr_data;
         else
            rd_data = mem[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= win;
         out_data  <= rd_data;
      end
   end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Tile sequencer: load A/B operands, stream them skewed into
// the PE grid, then drain the PE pipeline and signal done.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int ARRAY_DIM   = DEF_ARRAY_DIM,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int K_MAX       = DEF_K_MAX,
   parameter int DRAIN_EXTRA = DEF_DRAIN_EXTRA
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [$clog2(K_MAX+1)-1:0]  cfg_k,
   output logic                        cfg_err,
   output logic                        busy,
   output logic                        done,
   systolic_skew_feeder_if.slave       wr,
   output logic                        pe_clear,
   output logic [ARRAY_DIM*DATA_W-1:0] a_out,
   output logic [ARRAY_DIM-1:0]        a_valid,
   output logic [ARRAY_DIM*DATA_W-1:0] b_out,
   output logic [ARRAY_DIM-1:0]        b_valid
);

   localparam int KW        = $clog2(K_MAX + 1);
   localparam int AW        = (K_MAX > 1) ? $clog2(K_MAX) : 1;
   localparam int T_W       = $clog2(K_MAX + ARRAY_DIM);
   localparam int DRAIN_LEN = ARRAY_DIM - 1 + DRAIN_EXTRA;

   state_t         state;
   state_t         nxt;
   logic [KW-1:0]  k_q;
   logic [KW-1:0]  a_cnt;
   logic [KW-1:0]  b_cnt;
   logic [KW-1:0]  a_cnt_n;
   logic [KW-1:0]  b_cnt_n;
   logic [T_W-1:0] cnt;
   logic [T_W-1:0] t_last;
   logic [T_W-1:0] rd_t;
   logic           cfg_ok;
   logic           a_fire;
   logic           b_fire;
   logic           load_full;
   logic           rd_en;

   always_comb begin
      cfg_ok    = (cfg_k != '0) && (cfg_k <= KW'(K_MAX));
      a_fire    = wr.a_wr_valid && wr.a_wr_ready;
      b_fire    = wr.b_wr_valid && wr.b_wr_ready;
      a_cnt_n   = a_cnt + KW'(a_fire);
      b_cnt_n   = b_cnt + KW'(b_fire);
      load_full = (a_cnt_n == k_q) && (b_cnt_n == k_q);
      t_last    = T_W'(k_q) + T_W'(ARRAY_DIM - 2);
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:   if (start && cfg_ok) nxt = LOAD;
         LOAD:   if (load_full) nxt = STREAM;
         STREAM: if (cnt == t_last) nxt = DRAIN;
         DRAIN:  if (cnt == T_W'(DRAIN_LEN - 1)) nxt = DONE;
         DONE:   nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Lane registers hold next cycle's value, so the read slot
   // runs one step ahead of the visible stream index.
   always_comb begin
      busy          = (state != IDLE);
      done          = (state == DONE);
      wr.a_wr_ready = (state == LOAD) && (a_cnt < k_q);
      wr.b_wr_ready = (state == LOAD) && (b_cnt < k_q);
      rd_en         = ((state == LOAD) && (nxt == STREAM))
                   || ((state == STREAM) && (cnt != t_last));
      rd_t          = (state == STREAM) ? cnt + T_W'(1) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q      <= '0;
         a_cnt    <= '0;
         b_cnt    <= '0;
         cnt      <= '0;
         cfg_err  <= 1'b0;
         pe_clear <= 1'b0;
      end else begin
         cfg_err  <= (state == IDLE) && start && !cfg_ok;
         pe_clear <= (state == IDLE) && start && cfg_ok;
         if ((state == IDLE) && start && cfg_ok) begin
            k_q   <= cfg_k;
            a_cnt <= '0;
            b_cnt <= '0;
         end else begin
            a_cnt <= a_cnt_n;
            b_cnt <= b_cnt_n;
         end
         if (state != nxt)
            cnt <= '0;
         else if ((state == STREAM) || (state == DRAIN))
            cnt <= cnt + T_W'(1);
      end
   end

   for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
      skew_lane_buf #(
         .LANE   (i),
         .DATA_W (DATA_W),
         .K_MAX  (K_MAX),
         .AW     (AW),
         .KW     (KW),
         .T_W    (T_W)
      ) u_a (
         .clk       (clk),
         .rst       (rst),
         .we        (a_fire),
         .wr_addr   (a_cnt[AW-1:0]),
         .wr_data   (wr.a_wr_data[i*DATA_W +: DATA_W]),
         .rd_en     (rd_en),
         .rd_t      (rd_t),
         .k         (k_q),
         .out_data  (a_out[i*DATA_W +: DATA_W]),
         .out_valid (a_valid[i])
      );

      skew_lane_buf #(
         .LANE   (i),
         .DATA_W (DATA_W),
         .K_MAX  (K_MAX),
         .AW     (AW),
         .KW     (KW),
         .T_W    (T_W)
      ) u_b (
         .clk       (clk),
         .rst       (rst),
         .we        (b_fire),
         .wr_addr   (b_cnt[AW-1:0]),
         .wr_data   (wr.b_wr_data[i*DATA_W +: DATA_W]),
         .rd_en     (rd_en),
         .rd_t      (rd_t),
         .k         (k_q),
         .out_data  (b_out[i*DATA_W +: DATA_W]),
         .out_valid (b_valid[i])
      );
   end

endmodule
